// File: rtl/mux_n_reg_skid.sv
// mux_n_reg_skid
// Registered N:1 operand-select mux with a valid/ready handshake and a
// two-entry (output + skid) buffer so an ALU-side stall never drops a word.
// Selects at or above NUM_IN forward DFLT_VAL and flag sel_err with the word.
//
// Optional feature: define MUX_ERR_CNT_EN to build a saturating 8-bit count
// of accepted invalid selects on err_cnt. Without it, err_cnt is tied to 0.
//
// Parameter constraints: 2 <= NUM_IN <= 16 and 2**SEL_W >= NUM_IN.

module mux_n_reg_skid #(
    parameter int              WIDTH    = 8,
    parameter int              NUM_IN   = 3,
    parameter int              SEL_W    = 4,
    parameter logic [WIDTH-1:0] DFLT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH*NUM_IN-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    output logic [7:0]              err_cnt
);

    // Buffer occupancy: nothing held, OUT only, or OUT plus SKID.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t             occ_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic             sel_err_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             skid_err_reg;
    logic             in_ready_reg;

    logic [WIDTH-1:0] in_word [NUM_IN];
    logic [WIDTH-1:0] sel_data;
    logic             sel_bad;
    logic             accept;
    logic             consume;

    // Unpack the flat input bus into one lane per selectable source.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
            assign in_word[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Select the addressed lane; anything out of range yields the default
    // value and raises the error flag that travels with the word.
    always_comb begin
        sel_data = DFLT_VAL;
        sel_bad  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_word[k];
                sel_bad  = 1'b0;
            end
        end
    end

    // in_ready comes straight from a register, so upstream timing never
    // sees a path from out_ready.
    assign accept  = in_valid & in_ready_reg;
    assign consume = out_valid_reg & out_ready;

    // Occupancy FSM; OUT, SKID and in_ready are all updated here so every
    // handshake output is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_reg       <= OCC_EMPTY;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            sel_err_reg   <= 1'b0;
            skid_data_reg <= '0;
            skid_err_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (occ_reg)
                OCC_EMPTY: begin
                    if (accept) begin
                        out_data_reg  <= sel_data;
                        sel_err_reg   <= sel_bad;
                        out_valid_reg <= 1'b1;
                        occ_reg       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (consume && accept) begin
                        out_data_reg <= sel_data;
                        sel_err_reg  <= sel_bad;
                    end else if (consume) begin
                        // Data is left in place; only the flags drop.
                        out_valid_reg <= 1'b0;
                        sel_err_reg   <= 1'b0;
                        occ_reg       <= OCC_EMPTY;
                    end else if (accept) begin
                        skid_data_reg <= sel_data;
                        skid_err_reg  <= sel_bad;
                        in_ready_reg  <= 1'b0;
                        occ_reg       <= OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only a consume can occur.
                    if (consume) begin
                        out_data_reg <= skid_data_reg;
                        sel_err_reg  <= skid_err_reg;
                        in_ready_reg <= 1'b1;
                        occ_reg      <= OCC_ONE;
                    end
                end
                default: begin
                    occ_reg       <= OCC_EMPTY;
                    out_valid_reg <= 1'b0;
                    sel_err_reg   <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign sel_err   = sel_err_reg;

`ifdef MUX_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    // Count accepted invalid selects, holding at 8'hFF once saturated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_reg <= 8'h00;
        end else if (accept && sel_bad && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'h01;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_mux_n_reg_skid.sv
// Testbench for mux_n_reg_skid (default WIDTH=8, NUM_IN=3, SEL_W=4, DFLT_VAL=0).
// Directed vector table, hand-written reset / streaming / saturation
// sequences, and a queue-based scoreboard under random traffic.

module tb_mux_n_reg_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] in_data;
    logic [3:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    mux_n_reg_skid #(
        .WIDTH   (8),
        .NUM_IN  (3),
        .SEL_W   (4),
        .DFLT_VAL(8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel_err  (sel_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [3:0]  sel;
        logic [23:0] d;
        logic        rdy;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_err;
        logic        e_ir;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, settle 1 time unit.
    task automatic step(input logic v, input logic [3:0] s, input logic [23:0] d, input logic r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    logic [8:0] q[$];   // {sel_err, data}
    int         cnt_model;
    logic       acc;
    logic       cons;
    logic       rv;
    logic       rr;
    logic [3:0] rs;
    logic [23:0] rd;
    logic [7:0] rexp;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 4'd0;
        in_data   = 24'h0;
        out_ready = 1'b0;
        #12;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data",  {24'b0, out_data},  32'h00);
        chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
        chk("reset_sel_err",   {31'b0, sel_err},   32'd0);
        chk("reset_err_cnt",   {24'b0, err_cnt},   32'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //               v  sel   in_data     rdy  e_v e_data e_err e_ir
        vecs.push_back({1'b1, 4'd0, 24'hCCBBAA, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1});
        vecs.push_back({1'b1, 4'd1, 24'hCCBBAA, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b1});
        vecs.push_back({1'b1, 4'd2, 24'hCCBBAA, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b1});
        vecs.push_back({1'b1, 4'd3, 24'hCCBBAA, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1});
        vecs.push_back({1'b0, 4'd0, 24'hCCBBAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
        // backpressure: 01 into OUT, 02 into SKID, 03 held upstream
        vecs.push_back({1'b1, 4'd0, 24'h000001, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1});
        vecs.push_back({1'b1, 4'd0, 24'h000002, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0});
        vecs.push_back({1'b1, 4'd0, 24'h000003, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0});
        vecs.push_back({1'b1, 4'd0, 24'h000003, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1});
        vecs.push_back({1'b1, 4'd0, 24'h000003, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1});
        vecs.push_back({1'b0, 4'd0, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});
        // invalid word in OUT, valid word in SKID: error flag follows its word
        vecs.push_back({1'b1, 4'd3, 24'hCCBBAA, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1});
        vecs.push_back({1'b1, 4'd0, 24'h000044, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
        vecs.push_back({1'b0, 4'd0, 24'h000000, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1});
        vecs.push_back({1'b0, 4'd0, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].rdy);
            chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("vec%0d_sel_err", i),   {31'b0, sel_err},   {31'b0, vecs[i].e_err});
            chk($sformatf("vec%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].e_ir});
            if (vecs[i].e_valid)
                chk($sformatf("vec%0d_out_data", i), {24'b0, out_data}, {24'b0, vecs[i].e_data});
        end

`ifdef MUX_ERR_CNT_EN
        chk("table_err_cnt", {24'b0, err_cnt}, 32'd2);
`else
        chk("table_err_cnt", {24'b0, err_cnt}, 32'd0);
`endif

        // Reset while FULL: asynchronous clear before any edge.
        step(1'b1, 4'd0, 24'h000055, 1'b0);
        step(1'b1, 4'd0, 24'h000066, 1'b0);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("async_rst_out_data",  {24'b0, out_data},  32'h00);
        chk("async_rst_err_cnt",   {24'b0, err_cnt},   32'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 4'd0, 24'h000011, 1'b1);
        chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
        chk("post_rst_data",  {24'b0, out_data},  32'h11);

        // Simultaneous accept + consume from ONE: one word per cycle.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'd1, {8'h00, 8'(8'h20 + i), 8'h00}, 1'b1);
            chk($sformatf("stream%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
            chk($sformatf("stream%0d_data", i), {24'b0, out_data}, {24'b0, 8'(8'h20 + i)});
        end
        step(1'b0, 4'd0, 24'h0, 1'b1);
        chk("stream_drain_valid", {31'b0, out_valid}, 32'd0);

        // 300 invalid accepts: counter saturates.
        for (int i = 0; i < 300; i++) step(1'b1, 4'd3, 24'h123456, 1'b1);
        chk("inv_out_data", {24'b0, out_data}, 32'h00);
        chk("inv_sel_err",  {31'b0, sel_err},  32'd1);
`ifdef MUX_ERR_CNT_EN
        chk("inv_err_cnt_sat", {24'b0, err_cnt}, 32'hFF);
`else
        chk("inv_err_cnt_sat", {24'b0, err_cnt}, 32'h00);
`endif
        step(1'b0, 4'd0, 24'h0, 1'b1);

        // Random traffic against a queue scoreboard.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        cnt_model = 0;
        for (int c = 0; c < 1500; c++) begin
            rv = ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
            rd = 24'($urandom);
            acc  = rv && (q.size() < 2);
            cons = rr && (q.size() != 0);
            step(rv, rs, rd, rr);
            if (cons) void'(q.pop_front());
            if (acc) begin
                rexp = (rs < 4'd3) ? rd[rs*8 +: 8] : 8'h00;
                q.push_back({(rs >= 4'd3), rexp});
                if (rs >= 4'd3 && cnt_model < 255) cnt_model++;
            end
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) ||
                (q.size() != 0 && {sel_err, out_data} !== q[0])) begin
                errors++;
                $display("FAIL rand%0d actual v=%0b ir=%0b err=%0b d=%0h required v=%0b ir=%0b head=%0h",
                         c, out_valid, in_ready, sel_err, out_data,
                         (q.size() != 0), (q.size() < 2), (q.size() != 0) ? q[0] : 9'h0);
            end
        end
`ifdef MUX_ERR_CNT_EN
        chk("rand_err_cnt", {24'b0, err_cnt}, cnt_model);
`else
        chk("rand_err_cnt", {24'b0, err_cnt}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
